// File: rtl/nios_system_xb_gpio_in.sv
// nios_system_xb_gpio_in: Avalon-MM input port with sync, debounce, edge capture and irq
module nios_system_xb_gpio_in #(
  parameter int WIDTH = 32,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] s1, s2, filt, filt_d, mask, cap, sel, ev, clr;
  logic wr;
  logic unused_wd;
  assign unused_wd = &{1'b0, writedata};
  assign wr = chipselect & ~write_n;
  assign clr = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
  assign ev = (filt_d & ~filt & sel) | (~filt_d & filt & ~sel);
  if (DEBOUNCE_CYCLES == 0) begin : g_byp
    assign filt = s2;
  end else begin : g_deb
    logic [15:0] cnt;
    logic [WIDTH-1:0] prev, f;
    logic tick;
    assign tick = cnt == 16'(DEBOUNCE_CYCLES - 1);
    assign filt = f;
    // prescaler and two-tick agreement filter
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        cnt <= '0;
        prev <= '0;
        f <= '0;
      end else begin
        cnt <= tick ? '0 : cnt + 16'd1;
        if (tick) begin
          prev <= s2;
          f <= (s2 & ~(s2 ^ prev)) | (f & (s2 ^ prev));
        end
      end
  end
  // synchronizer, edge capture, control registers and interrupt
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      filt_d <= '0;
      cap <= '0;
      mask <= '0;
      sel <= '0;
      irq <= 1'b0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      filt_d <= filt;
      cap <= ev | (cap & ~clr);
      if (wr && address == 2'd1) mask <= writedata[WIDTH-1:0];
      if (wr && address == 2'd3) sel <= writedata[WIDTH-1:0];
      irq <= |(cap & mask);
    end
  // zero-wait-state read mux, upper bits zero
  always_comb begin
    readdata = '0;
    readdata[WIDTH-1:0] = address == 2'd0 ? filt : address == 2'd1 ? mask : address == 2'd2 ? cap : sel;
  end
endmodule
